// File: rtl/video_core_fifo.sv
// Elastic first-word-fall-through FIFO carrying {frame control, rgb} pixel words.
// Optional underrun monitor enabled by defining VIDEO_FIFO_UNDERRUN_EN.
module video_core_fifo #(
  parameter int unsigned RGB_SIZE    = 12,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12,
  parameter type         vga_fc_t    = logic [4:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_in_vld,
  output logic                       pipe_in_rdy,
  input  vga_fc_t                    pipe_in_fc,
  input  logic [RGB_SIZE-1:0]        pipe_in_rgb,
  input  logic                       pipe_out_rdy,
  output logic                       pipe_out_vld,
  output vga_fc_t                    pipe_out_fc,
  output logic [RGB_SIZE-1:0]        pipe_out_rgb,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       fifo_afull
`ifdef VIDEO_FIFO_UNDERRUN_EN
  ,
  output logic [15:0]                underrun_cnt,
  output logic                       underrun_flag
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  vga_fc_t             fc_mem  [DEPTH];
  logic [RGB_SIZE-1:0] rgb_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          afull_q, afull_d;
  logic          push, pop;

  // Handshakes depend only on registered level, so no rdy path crosses the FIFO.
  assign pipe_in_rdy  = (level_q != LW'(DEPTH));
  assign pipe_out_vld = (level_q != '0);
  assign push         = pipe_in_vld & pipe_in_rdy;
  assign pop          = pipe_out_vld & pipe_out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
    afull_d = (level_d >= LW'(AFULL_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fc_mem[wr_ptr_q]  <= pipe_in_fc;
      rgb_mem[wr_ptr_q] <= pipe_in_rgb;
    end
  end

  assign pipe_out_fc  = fc_mem[rd_ptr_q];
  assign pipe_out_rgb = rgb_mem[rd_ptr_q];
  assign fifo_level   = level_q;
  assign fifo_afull   = afull_q;

`ifdef VIDEO_FIFO_UNDERRUN_EN
  logic        armed_q, armed_d;
  logic [15:0] ucnt_q, ucnt_d;
  logic        uflag_q, uflag_d;
  logic        starve;

  // Starvation is only meaningful once the stream has actually started.
  assign starve = armed_q & pipe_out_rdy & ~pipe_out_vld;

  always_comb begin
    armed_d = armed_q | pop;
    ucnt_d  = ucnt_q;
    uflag_d = uflag_q;
    if (starve) begin
      uflag_d = 1'b1;
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      ucnt_q  <= '0;
      uflag_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      ucnt_q  <= ucnt_d;
      uflag_q <= uflag_d;
    end
  end

  assign underrun_cnt  = ucnt_q;
  assign underrun_flag = uflag_q;
`endif

endmodule
